// File: rtl/vector_cmd_sequencer_pkg.sv
// Shared types for the vector command sequencer: command opcodes, FSM states
// and the default coordinate width of the line drawer.
package vector_cmd_sequencer_pkg;

    localparam int COORD_W_DEF = 12;

    typedef enum logic [1:0] {
        OP_JUMP = 2'd0,
        OP_DRAW = 2'd1,
        OP_RSV2 = 2'd2,
        OP_RSV3 = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_BUSY = 1'b1
    } state_t;

    function automatic logic is_issuable(input logic [1:0] op);
        return (op == OP_JUMP) || (op == OP_DRAW);
    endfunction

endpackage

// File: rtl/vector_cmd_sequencer_if.sv
// Producer-side command handshake: the producer is the master, the sequencer
// FIFO is the slave.
interface vector_cmd_sequencer_if
    import vector_cmd_sequencer_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;

    modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_x, cmd_y, output cmd_ready);

endinterface

// File: rtl/vector_cmd_sequencer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight out of the
// register array so it is valid the cycle after the first push.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vector_cmd_sequencer.sv
// Feeds buffered jump/draw commands to the line drawer one pulse at a time,
// paced by the drawer's ready, and parks the beam after a long idle stretch.
module vector_cmd_sequencer
    import vector_cmd_sequencer_pkg::*;
#(
    parameter int COORD_W      = COORD_W_DEF,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARK_TIMEOUT = 65535,
    parameter int PARK_X       = 2048,
    parameter int PARK_Y       = 2048
) (
    input  logic                         clk,
    input  logic                         reset,
    vector_cmd_sequencer_if.slave        cmd,
    output logic [COORD_W-1:0]           x,
    output logic [COORD_W-1:0]           y,
    output logic                         draw,
    output logic                         jump,
    input  logic                         ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         parked
);

    localparam int ENTRY_W = 2 + 2 * COORD_W;
    localparam int PCW     = (PARK_TIMEOUT > 0) ? $clog2(PARK_TIMEOUT + 1) : 1;
    localparam bit PARK_EN = (PARK_TIMEOUT > 0);
    localparam logic [PCW-1:0] PARK_LAST = PCW'((PARK_TIMEOUT > 0) ? PARK_TIMEOUT - 1 : 0);
    localparam logic [PCW-1:0] PARK_MAX  = PCW'(PARK_TIMEOUT);

    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               pop;
    logic [1:0]         head_op;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;

    state_t             state;
    state_t             state_next;
    logic               wait_cnt;
    logic [PCW-1:0]     park_cnt;
    logic               park_qual;
    logic               park_hit;
    logic               issue_draw;
    logic               issue_jump;
    logic               load_cmd;
    logic               load_park;

    assign cmd.cmd_ready = !full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd.cmd_valid),
        .push_data ({cmd.cmd_op, cmd.cmd_x, cmd.cmd_y}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign head_op = head[ENTRY_W-1 -: 2];
    assign head_x  = head[2*COORD_W-1 -: COORD_W];
    assign head_y  = head[COORD_W-1:0];

    // Park only fires with an empty FIFO, so a pending command always beats it.
    assign park_qual = (state == ST_IDLE) && empty && ready && !parked;
    assign park_hit  = PARK_EN && park_qual && (park_cnt == PARK_LAST);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue_draw = 1'b0;
        issue_jump = 1'b0;
        load_cmd   = 1'b0;
        load_park  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ready && !empty) begin
                    pop = 1'b1;
                    if (is_issuable(head_op)) begin
                        load_cmd   = 1'b1;
                        issue_draw = (head_op == OP_DRAW);
                        issue_jump = (head_op == OP_JUMP);
                        state_next = ST_WAIT_BUSY;
                    end
                end else if (park_hit) begin
                    load_park  = 1'b1;
                    issue_jump = 1'b1;
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // Hold off re-issue until the drawer drops ready or two cycles pass.
                if (!ready || wait_cnt) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == ST_WAIT_BUSY) && (state_next == ST_WAIT_BUSY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            draw     <= 1'b0;
            jump     <= 1'b0;
            parked   <= 1'b0;
            park_cnt <= '0;
        end else begin
            draw <= issue_draw;
            jump <= issue_jump;
            if (load_park) begin
                x      <= COORD_W'(PARK_X);
                y      <= COORD_W'(PARK_Y);
                parked <= 1'b1;
            end else if (load_cmd) begin
                x      <= head_x;
                y      <= head_y;
                parked <= 1'b0;
            end
            if (!park_qual || park_hit) begin
                park_cnt <= '0;
            end else if (park_cnt != PARK_MAX) begin
                park_cnt <= park_cnt + 1'b1;
            end
        end
    end

endmodule
